branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 44 ++++
 rtl/branch_predictor.sv | 88 ++++++++
 tb/tb_branch_predictor.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Decode-side prediction port, evaluator-side update port and statistics
// outputs of the branch predictor, bundled as one interface.
interface branch_predictor_if #(
    parameter int XLEN = 32
) ();
    logic            predict_valid;
    logic [XLEN-1:0] predict_pc;
    logic            predict_branch;
    logic            predict_jump;
    logic            predict_jalr;
    logic [XLEN-1:0] predict_target;
    logic            branch_prediction;
    logic [XLEN-1:0] predicted_next_instruction;

    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            update_branch;
    logic            update_jump;
    logic            update_jalr;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic            update_mispredicted;

    logic [31:0]     resolved_count;
    logic [31:0]     mispredict_count;

    modport master (
        output predict_valid, predict_pc, predict_branch, predict_jump,
               predict_jalr, predict_target,
        input  branch_prediction, predicted_next_instruction,
        output update_valid, update_pc, update_branch, update_jump,
               update_jalr, update_taken, update_target, update_mispredicted,
        input  resolved_count, mispredict_count
    );

    modport slave (
        input  predict_valid, predict_pc, predict_branch, predict_jump,
               predict_jalr, predict_target,
        output branch_prediction, predicted_next_instruction,
        input  update_valid, update_pc, update_branch, update_jump,
               update_jalr, update_taken, update_target, update_mispredicted,
        output resolved_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters plus a JALR target
// table, untagged, with combinational prediction and resolved/mispredict stats.
module branch_predictor #(
    parameter int XLEN           = 32,
    parameter int BHT_INDEX_BITS = 6
) (
    input logic               clk,
    input logic               reset_n,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << BHT_INDEX_BITS;

    logic [1:0]                bht_q     [ENTRIES];
    logic [XLEN-1:0]           tgt_q     [ENTRIES];
    logic [ENTRIES-1:0]        tgt_vld_q;
    logic [31:0]               resolved_q;
    logic [31:0]               mispredict_q;

    logic [BHT_INDEX_BITS-1:0] pidx;
    logic [BHT_INDEX_BITS-1:0] uidx;
    logic [XLEN-1:0]           pc_plus4;
    logic                      pred_taken;
    logic [XLEN-1:0]           pred_next;
    logic                      unused_update_pc;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign pidx             = bp.predict_pc[BHT_INDEX_BITS+1:2];
    assign uidx             = bp.update_pc[BHT_INDEX_BITS+1:2];
    assign unused_update_pc = ^{bp.update_pc[XLEN-1:BHT_INDEX_BITS+2], bp.update_pc[1:0]};
    assign pc_plus4         = bp.predict_pc + XLEN'(4);

    // Prediction reads pre-update state; an update to the same index lands next cycle.
    always_comb begin
        pred_taken = 1'b0;
        pred_next  = pc_plus4;
        if (bp.predict_valid) begin
            if (bp.predict_branch) begin
                pred_taken = bht_q[pidx][1];
                if (bht_q[pidx][1])
                    pred_next = bp.predict_target;
            end else if (bp.predict_jump) begin
                pred_taken = 1'b1;
                if (!bp.predict_jalr)
                    pred_next = bp.predict_target;
                else if (tgt_vld_q[pidx])
                    pred_next = tgt_q[pidx];
            end
        end
    end

    assign bp.branch_prediction          = pred_taken;
    assign bp.predicted_next_instruction = pred_next;
    assign bp.resolved_count             = resolved_q;
    assign bp.mispredict_count           = mispredict_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
                tgt_q[i] <= '0;
            end
            tgt_vld_q    <= '0;
            resolved_q   <= '0;
            mispredict_q <= '0;
        end else if (bp.update_valid) begin
            if (bp.update_branch)
                bht_q[uidx] <= ctr_next(bht_q[uidx], bp.update_taken);
            // Only register-indirect jumps need a learned target.
            if (bp.update_jump && bp.update_jalr) begin
                tgt_q[uidx]     <= bp.update_target;
                tgt_vld_q[uidx] <= 1'b1;
            end
            if (bp.update_branch || bp.update_jump)
                resolved_q <= sat_inc32(resolved_q);
            if (bp.update_mispredicted)
                mispredict_q <= sat_inc32(mispredict_q);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference model pushes expected
// predictions when stimulus is driven; they are popped and compared on output.
module tb_branch_predictor;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bp ();

    branch_predictor #(.XLEN(XLEN), .BHT_INDEX_BITS(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (bp)
    );

    typedef struct packed {
        logic        pred;
        logic [31:0] nxt;
    } pexp_t;

    pexp_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  m_ctr [64];
    logic [31:0] m_tgt [64];
    logic        m_tv  [64];
    logic [31:0] m_res;
    logic [31:0] m_mis;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[i] = 2'b01;
            m_tgt[i] = 32'h0;
            m_tv[i]  = 1'b0;
        end
        m_res = 32'h0;
        m_mis = 32'h0;
    endtask

    function automatic pexp_t model_pred(input logic v, input logic [31:0] pc, input logic br,
                                         input logic jmp, input logic jalr, input logic [31:0] tgt);
        pexp_t r;
        logic [5:0] idx;
        idx   = pc[7:2];
        r.pred = 1'b0;
        r.nxt  = pc + 32'd4;
        if (v && br) begin
            r.pred = m_ctr[idx][1];
            if (r.pred) r.nxt = tgt;
        end else if (v && jmp) begin
            r.pred = 1'b1;
            if (!jalr) r.nxt = tgt;
            else if (m_tv[idx]) r.nxt = m_tgt[idx];
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bp.predict_valid = 0; bp.predict_pc = 0; bp.predict_branch = 0;
        bp.predict_jump = 0; bp.predict_jalr = 0; bp.predict_target = 0;
        bp.update_valid = 0; bp.update_pc = 0; bp.update_branch = 0;
        bp.update_jump = 0; bp.update_jalr = 0; bp.update_taken = 0;
        bp.update_target = 0; bp.update_mispredicted = 0;
    endtask

    task automatic drive_predict(input logic v, input logic [31:0] pc, input logic br,
                                 input logic jmp, input logic jalr, input logic [31:0] tgt);
        bp.predict_valid = v; bp.predict_pc = pc; bp.predict_branch = br;
        bp.predict_jump = jmp; bp.predict_jalr = jalr; bp.predict_target = tgt;
        exp_q.push_back(model_pred(v, pc, br, jmp, jalr, tgt));
    endtask

    task automatic check_predict(input string nm);
        pexp_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got pred=%0b next=%h", nm,
                     bp.branch_prediction, bp.predicted_next_instruction);
        end else begin
            e = exp_q.pop_front();
            if (bp.branch_prediction !== e.pred || bp.predicted_next_instruction !== e.nxt) begin
                errors++;
                $display("FAIL %s: got pred=%0b next=%h, expected pred=%0b next=%h", nm,
                         bp.branch_prediction, bp.predicted_next_instruction, e.pred, e.nxt);
            end
        end
    endtask

    task automatic set_update(input logic v, input logic [31:0] pc, input logic br,
                              input logic jmp, input logic jalr, input logic taken,
                              input logic [31:0] tgt, input logic misp);
        bp.update_valid = v; bp.update_pc = pc; bp.update_branch = br;
        bp.update_jump = jmp; bp.update_jalr = jalr; bp.update_taken = taken;
        bp.update_target = tgt; bp.update_mispredicted = misp;
    endtask

    task automatic tick();
        logic [5:0] idx;
        @(posedge clk);
        if (reset_n && bp.update_valid) begin
            idx = bp.update_pc[7:2];
            if (bp.update_branch) begin
                if (bp.update_taken && m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
                if (!bp.update_taken && m_ctr[idx] != 2'b00) m_ctr[idx] = m_ctr[idx] - 2'd1;
            end
            if (bp.update_jump && bp.update_jalr) begin
                m_tgt[idx] = bp.update_target;
                m_tv[idx]  = 1'b1;
            end
            if ((bp.update_branch || bp.update_jump) && m_res != 32'hFFFF_FFFF) m_res = m_res + 1;
            if (bp.update_mispredicted && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
        end
        @(negedge clk);
        bp.update_valid = 0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic br, input logic jmp,
                             input logic jalr, input logic taken, input logic [31:0] tgt,
                             input logic misp);
        set_update(1'b1, pc, br, jmp, jalr, taken, tgt, misp);
        tick();
    endtask

    task automatic check_counts(input string nm);
        #1;
        checks++;
        if (bp.resolved_count !== m_res || bp.mispredict_count !== m_mis) begin
            errors++;
            $display("FAIL %s: got resolved=%h mispredict=%h, expected resolved=%h mispredict=%h",
                     nm, bp.resolved_count, bp.mispredict_count, m_res, m_mis);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_counts("reset_counts");
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("reset_branch_nt");
        drive_predict(1, 32'h200, 0, 1, 1, 32'h999);
        check_predict("reset_jalr_pc4");
        // An update presented while reset is held must be dropped.
        set_update(1, 32'h100, 1, 0, 0, 1, 32'h0, 1);
        tick();
        tick();
        reset_n = 1'b1;
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("reset_update_dropped");
        check_counts("reset_counts_after");
    endtask

    task automatic test_branch_counter();
        for (int i = 0; i < 2; i++) do_update(32'h100, 1, 0, 0, 1, 32'h80, 0);
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("bht_two_taken");
        if (bp.predicted_next_instruction !== 32'h80) begin
            errors++;
            $display("FAIL bht_two_taken_const: got next=%h expected 00000080",
                     bp.predicted_next_instruction);
        end
        checks++;
        for (int i = 0; i < 3; i++) do_update(32'h100, 1, 0, 0, 0, 32'h80, 0);
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("bht_three_nt");
        do_update(32'h100, 1, 0, 0, 0, 32'h80, 0);
        do_update(32'h100, 1, 0, 0, 1, 32'h80, 0);
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("bht_sat_low_then_taken");
        do_update(32'h100, 1, 0, 0, 1, 32'h80, 0);
        drive_predict(1, 32'h100, 1, 0, 0, 32'h80);
        check_predict("bht_back_to_wt");
    endtask

    task automatic test_jalr();
        drive_predict(1, 32'h200, 0, 1, 1, 32'h999);
        check_predict("jalr_cold");
        do_update(32'h200, 0, 1, 1, 1, 32'h3C0, 1);
        drive_predict(1, 32'h200, 0, 1, 1, 32'h999);
        check_predict("jalr_learned");
        drive_predict(1, 32'h300, 0, 1, 1, 32'h999);
        check_predict("jalr_alias");
        drive_predict(1, 32'h204, 0, 1, 1, 32'h999);
        check_predict("jalr_other_index");
        do_update(32'h204, 0, 1, 0, 1, 32'h500, 0);
        drive_predict(1, 32'h204, 0, 1, 1, 32'h999);
        check_predict("jal_update_no_effect");
        drive_predict(1, 32'h204, 0, 1, 0, 32'h777);
        check_predict("jal_direct");
    endtask

    task automatic test_same_cycle();
        set_update(1, 32'h40, 1, 0, 0, 1, 32'h0, 0);
        drive_predict(1, 32'h40, 1, 0, 0, 32'h10);
        check_predict("same_cycle_old_state");
        tick();
        drive_predict(1, 32'h40, 1, 0, 0, 32'h10);
        check_predict("same_cycle_next");
    endtask

    task automatic test_edge_cases();
        drive_predict(1, 32'hFFFF_FFFC, 0, 0, 0, 32'h1234);
        check_predict("wrap_plain");
        drive_predict(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h1234);
        check_predict("wrap_branch_nt");
        drive_predict(0, 32'h100, 1, 0, 0, 32'h80);
        check_predict("predict_invalid");
        drive_predict(1, 32'h40, 0, 0, 0, 32'h10);
        check_predict("not_control_flow");
    endtask

    task automatic test_counters();
        logic [4:0] tbl [10];
        tbl = '{5'b11001, 5'b11000, 5'b10100, 5'b10111, 5'b01001,
                5'b11000, 5'b11001, 5'b10110, 5'b11000, 5'b11001};
        reset_n = 1'b0;
        model_reset();
        #1 reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            set_update(tbl[i][4], 32'h100 + 32'(i * 4), tbl[i][3], tbl[i][2], tbl[i][1],
                       1'b1, 32'(i * 64), tbl[i][0]);
            tick();
        end
        check_counts("counts_model");
        checks++;
        if (bp.resolved_count !== 32'd9 || bp.mispredict_count !== 32'd4) begin
            errors++;
            $display("FAIL counts_const: got resolved=%0d mispredict=%0d, expected 9 and 4",
                     bp.resolved_count, bp.mispredict_count);
        end
        #2 reset_n = 1'b0;
        model_reset();
        check_counts("async_reset_counts");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        force dut.resolved_q   = 32'hFFFF_FFFE;
        force dut.mispredict_q = 32'hFFFF_FFFE;
        #1;
        release dut.resolved_q;
        release dut.mispredict_q;
        m_res = 32'hFFFF_FFFE;
        m_mis = 32'hFFFF_FFFE;
        do_update(32'h80, 1, 0, 0, 1, 32'h0, 1);
        check_counts("sat_reach_max");
        do_update(32'h84, 0, 1, 0, 1, 32'h0, 1);
        check_counts("sat_hold_max");
        checks++;
        if (bp.resolved_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL sat_const: got resolved=%h expected ffffffff", bp.resolved_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ppc, upc;
        for (int i = 0; i < 300; i++) begin
            ppc = $urandom & 32'h0000_03FC;
            upc = $urandom & 32'h0000_03FC;
            set_update($urandom_range(0, 3) != 0, upc, 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), $urandom, 1'($urandom));
            drive_predict($urandom_range(0, 7) != 0, ppc, 1'($urandom), 1'($urandom),
                          1'($urandom), $urandom);
            check_predict("random_predict");
            tick();
            if (i % 25 == 24) check_counts("random_counts");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_branch_counter();
        test_jalr();
        test_same_cycle();
        test_edge_cases();
        test_counters();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
